// File: rtl/dm_access_unit_if.sv
// rtl/dm_access_unit_if.sv - datapath request/response and data-memory bus bundle for dm_access_unit
interface dm_access_unit_if #(
   parameter int ADDR_W = 10
);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sign_ext;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [31:0]       rdata;
   logic [ADDR_W-1:0] add_dm;
   logic [31:0]       dm_in;
   logic              dm_we;
   logic              dm_re;
   logic [31:0]       dm_out;

   // master: the access unit itself (initiator toward memory, responder to the datapath)
   modport master (
      input  req, we, size, sign_ext, addr, wdata, dm_out,
      output busy, done, err, rdata, add_dm, dm_in, dm_we, dm_re
   );

   // slave: the surrounding datapath and data memory
   modport slave (
      output req, we, size, sign_ext, addr, wdata, dm_out,
      input  busy, done, err, rdata, add_dm, dm_in, dm_we, dm_re
   );
endinterface

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - load/store unit for word-wide data memory, sub-word stores by read-modify-write
// Optional DM_RANGE_CHECK_EN: addresses beyond the memory are flagged as illegal instead of wrapping.
module dm_access_unit #(
   parameter int ADDR_W = 10
) (
   input  logic            clk,
   input  logic            rst,
   dm_access_unit_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              we_q;
   logic              sign_q;
   logic [1:0]        size_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       data_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic              align_bad;
   logic              range_bad;
   logic              illegal;
   logic [1:0]        lane;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       merged;

   logic              busy_c;
   logic              done_c;
   logic              dm_re_c;
   logic              dm_we_c;
   logic [ADDR_W-1:0] add_dm_c;
   logic [31:0]       dm_in_c;

   assign lane      = addr_q[1:0];
   assign word_addr = addr_q[ADDR_W+1:2];

`ifdef DM_RANGE_CHECK_EN
   assign range_bad = |bus.addr[31:ADDR_W+2];
`else
   assign range_bad = 1'b0;
`endif

   // Legality is judged on the live request so the verdict is ready at the accepting edge
   always_comb begin
      align_bad = 1'b0;
      case (bus.size)
         2'b00:   align_bad = 1'b0;
         2'b01:   align_bad = bus.addr[0];
         2'b10:   align_bad = |bus.addr[1:0];
         default: align_bad = 1'b1;
      endcase
      illegal = align_bad | range_bad;
   end

   function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] ln,
                                            input logic [1:0] sz, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{ln, 3'b000} +: 8];
      h = ln[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   fmt_load = {{24{sx & b[7]}}, b};
         2'b01:   fmt_load = {{16{sx & h[15]}}, h};
         default: fmt_load = w;
      endcase
   endfunction

   always_comb begin
      merged = data_q;
      case (size_q)
         2'b00:   merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
         2'b01: begin
            if (lane[1]) merged[31:16] = wdata_q[15:0];
            else         merged[15:0]  = wdata_q[15:0];
         end
         default: merged = wdata_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      busy_c   = 1'b1;
      done_c   = 1'b0;
      dm_re_c  = 1'b0;
      dm_we_c  = 1'b0;
      add_dm_c = '0;
      dm_in_c  = '0;
      case (state_q)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.req) begin
               if (illegal)               state_d = DONE;
               else if (!bus.we)          state_d = READ;
               else if (bus.size == 2'b10) state_d = WRITE;
               else                       state_d = READ;
            end
         end
         READ: begin
            dm_re_c  = 1'b1;
            add_dm_c = word_addr;
            state_d  = we_q ? WRITE : DONE;
         end
         WRITE: begin
            dm_we_c  = 1'b1;
            add_dm_c = word_addr;
            dm_in_c  = merged;
            state_d  = DONE;
         end
         DONE: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // rdata/err are loaded only on the edge that enters DONE, so they hold between completions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req) begin
                  we_q    <= bus.we;
                  sign_q  <= bus.sign_ext;
                  size_q  <= bus.size;
                  addr_q  <= bus.addr[ADDR_W+1:0];
                  wdata_q <= bus.wdata;
                  if (illegal) begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end
               end
            end
            READ: begin
               data_q <= bus.dm_out;
               if (!we_q) begin
                  err_q   <= 1'b0;
                  rdata_q <= fmt_load(bus.dm_out, lane, size_q, sign_q);
               end
            end
            WRITE: begin
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy_c;
   assign bus.done   = done_c;
   assign bus.err    = err_q;
   assign bus.rdata  = rdata_q;
   assign bus.dm_re  = dm_re_c;
   assign bus.dm_we  = dm_we_c;
   assign bus.add_dm = add_dm_c;
   assign bus.dm_in  = dm_in_c;

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - directed self-checking bench for dm_access_unit with a behavioural data memory
module tb_dm_access_unit;
   localparam int ADDR_W = 10;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   overlap;
   int   lat;
   int   n_re;
   int   n_we;
   logic [31:0] we_addr;
   logic [31:0] we_data;
   logic [31:0] mem [0:(1<<ADDR_W)-1];

   dm_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

   dm_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.dm_out = mem[bus.add_dm];

   always @(posedge clk) begin
      if (bus.dm_we) mem[bus.add_dm] <= bus.dm_in;
   end

   always @(negedge clk) begin
      if (bus.dm_we && bus.dm_re) overlap <= overlap + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
      int guard;
      guard = 0;
      @(negedge clk);
      while (bus.busy && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
      bus.addr = a; bus.wdata = d;
      n_re = 0; n_we = 0; we_addr = '0; we_data = '0;
      @(posedge clk); #1;
      bus.req = 1'b0;
      lat = 1;
      while (!bus.done && lat < 8) begin
         if (bus.dm_re) n_re++;
         if (bus.dm_we) begin
            n_we++;
            we_addr = 32'(bus.add_dm);
            we_data = bus.dm_in;
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.done) lat = 99;
   endtask

   initial begin
      vectors = 0; miscompares = 0; overlap = 0;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
      mem[0] = 32'hCAFEF00D;
      mem[1] = 32'h80FF7F01;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = '0; bus.wdata = '0;
      rst = 1'b1;
      #12;
      chk("rst_busy",   32'(bus.busy),   32'd0);
      chk("rst_done",   32'(bus.done),   32'd0);
      chk("rst_err",    32'(bus.err),    32'd0);
      chk("rst_rdata",  bus.rdata,       32'd0);
      chk("rst_strobe", {30'd0, bus.dm_we, bus.dm_re}, 32'd0);
      chk("rst_add_dm", 32'(bus.add_dm), 32'd0);
      chk("rst_dm_in",  bus.dm_in,       32'd0);
      @(negedge clk); rst = 1'b0;

      access(1'b0, 2'b00, 1'b1, 32'h6, 32'h0);
      chk("lb_sx_lat",   lat, 2);
      chk("lb_sx_rdata", bus.rdata, 32'hFFFFFFFF);
      chk("lb_sx_err",   32'(bus.err), 32'd0);
      chk("lb_sx_nre",   n_re, 1);
      chk("lb_sx_nwe",   n_we, 0);

      access(1'b0, 2'b00, 1'b0, 32'h6, 32'h0);
      chk("lbu_rdata", bus.rdata, 32'h000000FF);

      access(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AB);
      chk("sb_lat",   lat, 3);
      chk("sb_nre",   n_re, 1);
      chk("sb_nwe",   n_we, 1);
      chk("sb_dm_in", we_data, 32'h80FFAB01);
      chk("sb_rdata", bus.rdata, 32'd0);
      chk("sb_err",   32'(bus.err), 32'd0);

      access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      chk("lw_rdata", bus.rdata, 32'h80FFAB01);
      repeat (3) @(posedge clk);
      #1;
      chk("lw_hold_rdata", bus.rdata, 32'h80FFAB01);
      chk("lw_hold_done",  32'(bus.done), 32'd0);

      access(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678);
      chk("sw_lat",    lat, 2);
      chk("sw_nre",    n_re, 0);
      chk("sw_nwe",    n_we, 1);
      chk("sw_add_dm", we_addr, 32'd2);
      chk("sw_dm_in",  we_data, 32'h12345678);

      access(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
      chk("lh_hi_rdata", bus.rdata, 32'h00001234);
      access(1'b0, 2'b01, 1'b1, 32'h8, 32'h0);
      chk("lh_lo_rdata", bus.rdata, 32'h00005678);
      access(1'b0, 2'b00, 1'b1, 32'hB, 32'h0);
      chk("lb_lane3",    bus.rdata, 32'h00000012);
      access(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
      chk("lh_neg",      bus.rdata, 32'hFFFF80FF);

      access(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF);
      chk("sh_lat",   lat, 3);
      chk("sh_dm_in", we_data, 32'hBEEFAB01);

      access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
      chk("lw_mis_lat",   lat, 1);
      chk("lw_mis_err",   32'(bus.err), 32'd1);
      chk("lw_mis_rdata", bus.rdata, 32'd0);
      chk("lw_mis_strb",  n_re + n_we, 0);

      access(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
      chk("lh_mis_lat",  lat, 1);
      chk("lh_mis_err",  32'(bus.err), 32'd1);
      chk("lh_mis_strb", n_re + n_we, 0);

      access(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF);
      chk("sz11_lat",   lat, 1);
      chk("sz11_err",   32'(bus.err), 32'd1);
      chk("sz11_rdata", bus.rdata, 32'd0);
      chk("sz11_strb",  n_re + n_we, 0);
      chk("sz11_mem0",  mem[0], 32'hCAFEF00D);

      // abort a byte store while it is still in its read phase
      @(negedge clk);
      while (bus.busy) @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = 32'h8; bus.wdata = 32'h000000CC;
      @(posedge clk); #1;
      bus.req = 1'b0;
      chk("abort_in_read", 32'(bus.dm_re), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy",   32'(bus.busy), 32'd0);
      chk("abort_strobe", {30'd0, bus.dm_we, bus.dm_re}, 32'd0);
      chk("abort_add_dm", 32'(bus.add_dm), 32'd0);
      chk("abort_rdata",  bus.rdata, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("abort_mem2", mem[2], 32'h12345678);
      access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      chk("post_abort_lat",   lat, 2);
      chk("post_abort_rdata", bus.rdata, 32'h12345678);

      access(1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0);
`ifdef DM_RANGE_CHECK_EN
      chk("range_lat",   lat, 1);
      chk("range_err",   32'(bus.err), 32'd1);
      chk("range_rdata", bus.rdata, 32'd0);
`else
      chk("wrap_lat",   lat, 2);
      chk("wrap_err",   32'(bus.err), 32'd0);
      chk("wrap_rdata", bus.rdata, 32'hCAFEF00D);
`endif

      chk("strobe_overlap", overlap, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
